// File: rtl/branch_pkg.sv
// Shared types for the execute-stage branch resolver: condition codes, the NZCV
// flag layout and the condition evaluator.
package branch_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'h0,
    CondNe = 4'h1,
    CondGt = 4'h2,
    CondLt = 4'h3,
    CondGe = 4'h4,
    CondLe = 4'h5,
    CondHi = 4'h6,
    CondLs = 4'h7,
    CondHs = 4'h8,
    CondLo = 4'h9,
    CondMi = 4'hA,
    CondPl = 4'hB,
    CondVs = 4'hC,
    CondVc = 4'hD,
    CondAl = 4'hE,
    CondNv = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic cond_eval(input cond_e cond, input flags_t f);
    logic r;
    r = 1'b0;
    case (cond)
      CondEq:  r = f.z;
      CondNe:  r = ~f.z;
      CondGt:  r = ~f.z & (f.n == f.v);
      CondLt:  r = (f.n != f.v);
      CondGe:  r = (f.n == f.v);
      CondLe:  r = f.z | (f.n != f.v);
      CondHi:  r = f.c & ~f.z;
      CondLs:  r = ~f.c | f.z;
      CondHs:  r = f.c;
      CondLo:  r = ~f.c;
      CondMi:  r = f.n;
      CondPl:  r = ~f.n;
      CondVs:  r = f.v;
      CondVc:  r = ~f.v;
      CondAl:  r = 1'b1;
      CondNv:  r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Bimodal branch history table: DEPTH 2-bit saturating counters with one
// combinational read port and one registered update port.
module bht_2bit #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_taken,
  input  logic          upd_we,
  input  logic [IW-1:0] upd_idx,
  input  logic          upd_taken
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_we) begin
      if (upd_taken && (ctr_q[upd_idx] != 2'b11)) begin
        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
      end else if (!upd_taken && (ctr_q[upd_idx] != 2'b00)) begin
        ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
      end
    end
  end

  // Counters come out of reset weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Reads see the array before any update landing on the same edge.
  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: NZCV flag register with pending-producer
// scoreboard and forwarding, registered resolution, and the fetch predictor.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned BHT_DEPTH    = 64,
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned INSTR_BYTES  = 4,
  parameter int unsigned FWD_EN       = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flag_issue,
  output logic          flag_full,
  input  logic          flag_we,
  input  logic [3:0]    flag_in,
  output logic [3:0]    flags_q,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [3:0]    br_cond,
  input  logic [AW-1:0] br_pc,
  input  logic [AW-1:0] br_target,
  input  logic          br_pred_taken,
  input  logic          flush,
  output logic          res_valid,
  output logic          res_taken,
  output logic          res_mispredict,
  output logic [AW-1:0] res_redirect,
  input  logic [AW-1:0] pred_pc,
  output logic          pred_taken
);

  localparam int unsigned IW   = $clog2(BHT_DEPTH);
  localparam int unsigned OffW = $clog2(INSTR_BYTES);
  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_INFLIGHT);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  logic [CntW-1:0] pend_cnt_q, pend_cnt_d;
  logic [3:0]      flags_d;
  logic            res_valid_q, res_valid_d;
  logic            res_taken_q, res_taken_d;
  logic            res_mispredict_q, res_mispredict_d;
  logic [AW-1:0]   res_redirect_q, res_redirect_d;
  logic            upd_we_q, upd_we_d;
  logic [IW-1:0]   upd_idx_q, upd_idx_d;
  logic            upd_taken_q, upd_taken_d;

  cond_e   cond;
  flags_t  eff_flags;
  logic    fwd;
  logic    uncond;
  logic    accept;
  logic    br_taken;
  logic [AW-1:0] fall_through;
  logic    unused_pc;

  assign unused_pc = ^{br_pc, pred_pc};

  // Scoreboard and architectural flags
  assign flag_full = (pend_cnt_q == MaxCnt);

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (flag_issue && flag_we) begin
      pend_cnt_d = pend_cnt_q;
    end else if (flag_issue && !flag_full) begin
      pend_cnt_d = pend_cnt_q + OneCnt;
    end else if (flag_we && (pend_cnt_q != '0)) begin
      pend_cnt_d = pend_cnt_q - OneCnt;
    end
    flags_d = flag_we ? flag_in : flags_q;
  end

  // Branch acceptance and condition evaluation
  assign fwd       = (FWD_EN != 0) && flag_we;
  assign eff_flags = fwd ? flags_t'(flag_in) : flags_t'(flags_q);
  assign cond      = cond_e'(br_cond);
  assign uncond    = (cond == CondAl) || (cond == CondNv);

  // A branch may pass a single outstanding producer only when that producer's
  // flags are forwarded this very cycle.
  assign br_ready = ~flush & (uncond | (pend_cnt_q == '0) | (fwd & (pend_cnt_q == OneCnt)));
  assign accept   = br_valid & br_ready;
  assign br_taken = cond_eval(cond, eff_flags);
  assign fall_through = br_pc + AW'(INSTR_BYTES);

  always_comb begin
    res_valid_d      = accept;
    res_taken_d      = res_taken_q;
    res_mispredict_d = res_mispredict_q;
    res_redirect_d   = res_redirect_q;
    upd_we_d         = accept;
    upd_idx_d        = upd_idx_q;
    upd_taken_d      = upd_taken_q;
    if (accept) begin
      res_taken_d      = br_taken;
      res_mispredict_d = br_taken != br_pred_taken;
      res_redirect_d   = br_taken ? br_target : fall_through;
      upd_idx_d        = br_pc[OffW +: IW];
      upd_taken_d      = br_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt_q       <= '0;
      flags_q          <= '0;
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_redirect_q   <= '0;
      upd_we_q         <= 1'b0;
      upd_idx_q        <= '0;
      upd_taken_q      <= 1'b0;
    end else begin
      pend_cnt_q       <= pend_cnt_d;
      flags_q          <= flags_d;
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      res_redirect_q   <= res_redirect_d;
      upd_we_q         <= upd_we_d;
      upd_idx_q        <= upd_idx_d;
      upd_taken_q      <= upd_taken_d;
    end
  end

  // A late flush squashes the visible pulse but not the predictor training.
  assign res_valid      = res_valid_q & ~flush;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign res_redirect   = res_redirect_q;

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IW    (IW)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pred_pc[OffW +: IW]),
    .rd_taken  (pred_taken),
    .upd_we    (upd_we_q),
    .upd_idx   (upd_idx_q),
    .upd_taken (upd_taken_q)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run against a behavioural model of flags, scoreboard and predictor.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_issue, flag_we, br_valid, br_pred_taken, flush;
  logic [3:0]  flag_in, br_cond;
  logic [31:0] br_pc, br_target, pred_pc;

  logic        flag_full, br_ready, res_valid, res_taken, res_mispredict, pred_taken;
  logic [3:0]  flags_q;
  logic [31:0] res_redirect;

  logic        nf_flag_full, nf_br_ready, nf_res_valid, nf_res_taken, nf_res_mispredict;
  logic        nf_pred_taken;
  logic [3:0]  nf_flags_q;
  logic [31:0] nf_res_redirect;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.AW(32), .BHT_DEPTH(64), .MAX_INFLIGHT(3), .INSTR_BYTES(4), .FWD_EN(1))
  dut (
    .clk(clk), .rst(rst), .flag_issue(flag_issue), .flag_full(flag_full), .flag_we(flag_we),
    .flag_in(flag_in), .flags_q(flags_q), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_pc(br_pc), .br_target(br_target), .br_pred_taken(br_pred_taken),
    .flush(flush), .res_valid(res_valid), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_redirect(res_redirect), .pred_pc(pred_pc),
    .pred_taken(pred_taken)
  );

  branch_resolve_unit #(.AW(32), .BHT_DEPTH(64), .MAX_INFLIGHT(3), .INSTR_BYTES(4), .FWD_EN(0))
  dut_nf (
    .clk(clk), .rst(rst), .flag_issue(flag_issue), .flag_full(nf_flag_full),
    .flag_we(flag_we), .flag_in(flag_in), .flags_q(nf_flags_q), .br_valid(br_valid),
    .br_ready(nf_br_ready), .br_cond(br_cond), .br_pc(br_pc), .br_target(br_target),
    .br_pred_taken(br_pred_taken), .flush(flush), .res_valid(nf_res_valid),
    .res_taken(nf_res_taken), .res_mispredict(nf_res_mispredict),
    .res_redirect(nf_res_redirect), .pred_pc(pred_pc), .pred_taken(nf_pred_taken)
  );

  // Behavioural model of the forwarding instance
  logic [3:0]  m_flags;
  int          m_cnt;
  int          m_bht [64];
  bit          m_pend, m_res_taken, m_res_mis;
  logic [31:0] m_res_redir;
  bit          m_upd, m_upd_taken;
  int          m_upd_idx;
  bit          e_ready, e_accept, e_taken, e_pred, e_res_valid;

  function automatic bit ref_cond(input int c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      0:  return z;
      1:  return !z;
      2:  return !z && (n == v);
      3:  return n != v;
      4:  return n == v;
      5:  return z || (n != v);
      6:  return cf && !z;
      7:  return !cf || z;
      8:  return cf;
      9:  return !cf;
      10: return n;
      11: return !n;
      12: return v;
      13: return !v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic model_reset();
    m_flags = '0; m_cnt = 0; m_pend = 0; m_res_taken = 0; m_res_mis = 0; m_res_redir = '0;
    m_upd = 0; m_upd_idx = 0; m_upd_taken = 0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  task automatic idle();
    flag_issue = 0; flag_we = 0; flag_in = '0; br_valid = 0; br_cond = '0; br_pc = '0;
    br_target = '0; br_pred_taken = 0; flush = 0;
  endtask

  task automatic eval_model();
    logic [3:0] eff;
    eff = flag_we ? flag_in : m_flags;
    e_ready = !flush && (br_cond >= 4'd14 || m_cnt == 0 || (flag_we && m_cnt == 1));
    e_accept = br_valid && e_ready;
    e_taken = ref_cond(int'(br_cond), eff);
    e_pred = m_bht[idx_of(pred_pc)] >= 2;
    e_res_valid = m_pend && !flush;
  endtask

  // Advance one clock: model follows the edge, returns at the next falling edge.
  task automatic commit();
    eval_model();
    @(posedge clk);
    if (m_upd) begin
      if (m_upd_taken) m_bht[m_upd_idx] = (m_bht[m_upd_idx] < 3) ? m_bht[m_upd_idx] + 1 : 3;
      else m_bht[m_upd_idx] = (m_bht[m_upd_idx] > 0) ? m_bht[m_upd_idx] - 1 : 0;
    end
    m_upd = e_accept; m_upd_idx = idx_of(br_pc); m_upd_taken = e_taken;
    m_pend = e_accept;
    if (e_accept) begin
      m_res_taken = e_taken;
      m_res_mis = e_taken != br_pred_taken;
      m_res_redir = e_taken ? br_target : br_pc + 32'd4;
    end
    if (flag_we) m_flags = flag_in;
    if (flag_issue && flag_we) m_cnt = m_cnt;
    else if (flag_issue && m_cnt < 3) m_cnt++;
    else if (flag_we && m_cnt > 0) m_cnt--;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); br_valid = 1; br_cond = 4'hE; br_pc = 32'h40; br_target = 32'h1000;
    flag_we = 1; flag_in = 4'hF;
    commit();
    flag_we = 0; flag_issue = 1;
    commit();
    idle(); pred_pc = 32'h40; #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_valid got=%0b exp=1", res_valid); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL reset_pre_pred got=%0b exp=1", pred_taken); end
    rst = 1; #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", res_valid); end
    checks++; if (flags_q !== 4'h0) begin errors++; $display("FAIL reset_flags got=%0h exp=0", flags_q); end
    checks++; if (dut.pend_cnt_q !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", dut.pend_cnt_q); end
    checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%0b exp=0", res_taken); end
    for (int i = 0; i < 64; i++) begin
      pred_pc = 32'(i * 4); #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred idx=%0d got=%0b exp=0", i, pred_taken); end
    end
    model_reset();
    @(negedge clk); rst = 0;
    commit();
  endtask

  task automatic test_stall_forward();
    idle(); flag_issue = 1;
    commit();
    flag_issue = 0; br_valid = 1; br_cond = 4'h0; br_pc = 32'h200; br_target = 32'h300;
    for (int t = 1; t <= 2; t++) begin
      #1;
      checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL stall_ready T%0d got=%0b exp=0", t, br_ready); end
      checks++; if (nf_br_ready !== 1'b0) begin errors++; $display("FAIL stall_nf_ready T%0d got=%0b exp=0", t, nf_br_ready); end
      commit();
    end
    flag_we = 1; flag_in = 4'b0100; #1;
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready got=%0b exp=1", br_ready); end
    checks++; if (nf_br_ready !== 1'b0) begin errors++; $display("FAIL nofwd_ready_T3 got=%0b exp=0", nf_br_ready); end
    commit();
    flag_we = 0; #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL fwd_res_valid got=%0b exp=1", res_valid); end
    checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL fwd_res_taken got=%0b exp=1", res_taken); end
    checks++; if (res_redirect !== 32'h300) begin errors++; $display("FAIL fwd_redirect got=%0h exp=300", res_redirect); end
    checks++; if (nf_br_ready !== 1'b1) begin errors++; $display("FAIL nofwd_ready_T4 got=%0b exp=1", nf_br_ready); end
    commit();
    idle(); #1;
    checks++; if (nf_res_valid !== 1'b1) begin errors++; $display("FAIL nofwd_res_valid got=%0b exp=1", nf_res_valid); end
    checks++; if (nf_res_taken !== 1'b1) begin errors++; $display("FAIL nofwd_res_taken got=%0b exp=1", nf_res_taken); end
    commit();
  endtask

  task automatic test_unsigned_signed();
    idle(); flag_we = 1; flag_in = 4'b1010;
    commit();
    idle(); br_valid = 1; br_cond = 4'h6; br_pc = 32'h100; br_target = 32'h2000; #1;
    checks++; if (flags_q !== 4'b1010) begin errors++; $display("FAIL cond_flags got=%0h exp=a", flags_q); end
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL cond_ready got=%0b exp=1", br_ready); end
    commit();
    br_cond = 4'h2; #1;
    checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL hi_taken got=%0b exp=1", res_taken); end
    checks++; if (res_mispredict !== 1'b1) begin errors++; $display("FAIL hi_mispredict got=%0b exp=1", res_mispredict); end
    checks++; if (res_redirect !== 32'h2000) begin errors++; $display("FAIL hi_redirect got=%0h exp=2000", res_redirect); end
    commit();
    br_cond = 4'h3; br_pred_taken = 1; #1;
    checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL gt_taken got=%0b exp=0", res_taken); end
    checks++; if (res_mispredict !== 1'b0) begin errors++; $display("FAIL gt_mispredict got=%0b exp=0", res_mispredict); end
    checks++; if (res_redirect !== 32'h104) begin errors++; $display("FAIL gt_redirect got=%0h exp=104", res_redirect); end
    commit();
    idle(); #1;
    checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL lt_taken got=%0b exp=1", res_taken); end
    checks++; if (res_mispredict !== 1'b0) begin errors++; $display("FAIL lt_mispredict got=%0b exp=0", res_mispredict); end
    commit();
  endtask

  task automatic test_bht_saturation();
    int t_old[3] = '{0, 1, 1};
    int n_old[4] = '{1, 1, 0, 0};
    int n_new[4] = '{1, 0, 0, 0};
    idle(); br_pc = 32'h40; br_target = 32'h80;
    for (int k = 0; k < 3; k++) begin
      br_valid = 1; br_cond = 4'hE;
      commit();
      br_valid = 0; pred_pc = 32'h40; #1;
      checks++; if (pred_taken !== t_old[k][0]) begin errors++; $display("FAIL bht_t_old k=%0d got=%0b exp=%0d", k, pred_taken, t_old[k]); end
      commit();
      pred_pc = 32'h140; #1;
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL bht_t_new k=%0d got=%0b exp=1", k, pred_taken); end
    end
    for (int k = 0; k < 4; k++) begin
      br_valid = 1; br_cond = 4'hF;
      commit();
      br_valid = 0; pred_pc = 32'h140; #1;
      checks++; if (pred_taken !== n_old[k][0]) begin errors++; $display("FAIL bht_n_old k=%0d got=%0b exp=%0d", k, pred_taken, n_old[k]); end
      commit();
      pred_pc = 32'h40; #1;
      checks++; if (pred_taken !== n_new[k][0]) begin errors++; $display("FAIL bht_n_new k=%0d got=%0b exp=%0d", k, pred_taken, n_new[k]); end
    end
  endtask

  task automatic test_scoreboard();
    idle(); flag_issue = 1;
    for (int k = 1; k <= 4; k++) begin
      commit(); #1;
      checks++; if (dut.pend_cnt_q !== 2'((k > 3) ? 3 : k)) begin errors++; $display("FAIL sb_cnt k=%0d got=%0d", k, dut.pend_cnt_q); end
      checks++; if (flag_full !== (k >= 3)) begin errors++; $display("FAIL sb_full k=%0d got=%0b exp=%0b", k, flag_full, k >= 3); end
    end
    flag_we = 1; flag_in = 4'h3;
    commit(); #1;
    checks++; if (dut.pend_cnt_q !== 2'd3) begin errors++; $display("FAIL sb_hold got=%0d exp=3", dut.pend_cnt_q); end
    checks++; if (flags_q !== 4'h3) begin errors++; $display("FAIL sb_hold_flags got=%0h exp=3", flags_q); end
    idle(); br_valid = 1; br_cond = 4'h0; #1;
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL sb_eq_stall got=%0b exp=0", br_ready); end
    br_cond = 4'hE; br_pc = 32'h300; br_target = 32'h500; #1;
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL sb_al_ready got=%0b exp=1", br_ready); end
    commit();
    idle(); #1;
    checks++; if (res_valid !== 1'b1 || res_redirect !== 32'h500) begin errors++; $display("FAIL sb_al_res got=%0b/%0h exp=1/500", res_valid, res_redirect); end
    flag_we = 1;
    for (int k = 0; k < 3; k++) begin flag_in = 4'(k); commit(); end
    flag_in = 4'h9;
    commit(); #1;
    checks++; if (flags_q !== 4'h9) begin errors++; $display("FAIL sb_floor_flags got=%0h exp=9", flags_q); end
    checks++; if (dut.pend_cnt_q !== 2'd0) begin errors++; $display("FAIL sb_floor_cnt got=%0d exp=0", dut.pend_cnt_q); end
    checks++; if (flag_full !== 1'b0) begin errors++; $display("FAIL sb_floor_full got=%0b exp=0", flag_full); end
    idle();
    commit();
  endtask

  task automatic test_flush_wrap();
    idle(); pred_pc = 32'h1C0; br_valid = 1; br_cond = 4'hE; br_pc = 32'h1C0; flush = 1; #1;
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0b exp=0", br_ready); end
    commit();
    idle(); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_res got=%0b exp=0", res_valid); end
    commit(); commit(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL flush_bht got=%0b exp=0", pred_taken); end
    br_valid = 1; br_cond = 4'hE; br_pc = 32'h1C0;
    commit();
    idle(); flush = 1; #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL late_flush_res got=%0b exp=0", res_valid); end
    commit();
    flush = 0; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL late_flush_bht got=%0b exp=1", pred_taken); end
    br_valid = 1; br_cond = 4'hF; br_pc = 32'hFFFF_FFFC; br_target = 32'h1234; br_pred_taken = 1;
    commit();
    idle(); #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%0b exp=1", res_valid); end
    checks++; if (res_redirect !== 32'h0) begin errors++; $display("FAIL wrap_redirect got=%0h exp=0", res_redirect); end
    checks++; if (res_mispredict !== 1'b1) begin errors++; $display("FAIL wrap_mispredict got=%0b exp=1", res_mispredict); end
    commit();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom % 10) == 0;
      flag_issue = ($urandom % 3) == 0;
      flag_we = (m_cnt > 0) ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      if (m_cnt == 3 && flag_issue) flag_we = 0;
      flag_in = 4'($urandom);
      br_valid = $urandom % 2;
      br_cond = 4'($urandom);
      br_pc = (($urandom % 20) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 31) * 4 + ($urandom % 2) * 256);
      br_target = $urandom;
      br_pred_taken = $urandom % 2;
      pred_pc = 32'($urandom_range(0, 63) * 4);
      #1; eval_model();
      checks++; if (br_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, br_ready, e_ready); end
      checks++; if (res_valid !== e_res_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, res_valid, e_res_valid); end
      checks++; if (res_taken !== m_res_taken) begin errors++; $display("FAIL rnd_taken c=%0d got=%0b exp=%0b", c, res_taken, m_res_taken); end
      checks++; if (res_mispredict !== m_res_mis) begin errors++; $display("FAIL rnd_mis c=%0d got=%0b exp=%0b", c, res_mispredict, m_res_mis); end
      checks++; if (res_redirect !== m_res_redir) begin errors++; $display("FAIL rnd_redir c=%0d got=%0h exp=%0h", c, res_redirect, m_res_redir); end
      checks++; if (flags_q !== m_flags) begin errors++; $display("FAIL rnd_flags c=%0d got=%0h exp=%0h", c, flags_q, m_flags); end
      checks++; if (flag_full !== (m_cnt == 3)) begin errors++; $display("FAIL rnd_full c=%0d got=%0b exp=%0b", c, flag_full, m_cnt == 3); end
      checks++; if (pred_taken !== e_pred) begin errors++; $display("FAIL rnd_pred c=%0d got=%0b exp=%0b", c, pred_taken, e_pred); end
      commit();
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; idle(); pred_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_stall_forward();
    test_unsigned_signed();
    test_bht_saturation();
    test_scoreboard();
    test_flush_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
